// File: rtl/dma_bus_arbiter.sv
// OAM DMA engine and CPU/DMA arbiter for the single external memory port, with internal HRAM.
// Optional: define DMA_CPU_STALL_EN to drive o_CPU_Wait from o_DMA_Active (tied low otherwise).
module dma_bus_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          DMA_LENGTH   = 160,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic [15:0] i_CPU_Address,
    input  logic [7:0]  i_CPU_Data,
    input  logic        i_CPU_Write,
    input  logic        i_CPU_Read,
    output logic [7:0]  o_CPU_Data,
    output logic        o_CPU_Wait,
    input  logic [7:0]  i_Mem_Data,
    output logic [15:0] o_Mem_Address,
    output logic [7:0]  o_Mem_Data,
    output logic        o_Mem_Write,
    output logic        o_Mem_Read,
    output logic        o_DMA_Active
);

    localparam int         HRAM_DEPTH = int'(HRAM_HI) - int'(HRAM_LO) + 1;
    localparam int         HRAM_AW    = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;
    localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  byte_q, byte_d;
    logic        active_q, active_d;

    logic [7:0]  hram_mem [HRAM_DEPTH];

    logic               cpu_hits_reg;
    logic               cpu_hits_hram;
    logic               cpu_hits_ext;
    logic               dma_reg_write;
    logic               hram_write;
    logic [HRAM_AW-1:0] hram_index;

    always_comb begin
        cpu_hits_reg  = (i_CPU_Address == DMA_REG_ADDR);
        cpu_hits_hram = (i_CPU_Address >= HRAM_LO) && (i_CPU_Address <= HRAM_HI) && !cpu_hits_reg;
        cpu_hits_ext  = !cpu_hits_reg && !cpu_hits_hram;
        dma_reg_write = i_CPU_Write && cpu_hits_reg;
        hram_write    = i_CPU_Write && cpu_hits_hram;
        hram_index    = HRAM_AW'(i_CPU_Address - HRAM_LO);
    end

    // Next-state logic; a register write overrides whatever the FSM was doing (restart).
    always_comb begin
        state_d   = state_q;
        dma_reg_d = dma_reg_q;
        index_d   = index_q;
        byte_d    = byte_q;
        if (i_Enable) begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_START: begin
                    index_d = 8'h00;
                    state_d = ST_READ;
                end
                ST_READ: begin
                    byte_d  = i_Mem_Data;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 8'h01;
                        state_d = ST_READ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (dma_reg_write) begin
                dma_reg_d = i_CPU_Data;
                state_d   = ST_START;
            end
        end
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_q   <= ST_IDLE;
            dma_reg_q <= 8'h00;
            index_q   <= 8'h00;
            byte_q    <= 8'h00;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dma_reg_q <= dma_reg_d;
            index_q   <= index_d;
            byte_q    <= byte_d;
            active_q  <= active_d;
        end
    end

    // HRAM is deliberately left out of reset so code running from it survives.
    always_ff @(posedge i_Clk) begin
        if (i_nRst && i_Enable && hram_write) begin
            hram_mem[hram_index] <= i_CPU_Data;
        end
    end

    always_comb begin
        o_Mem_Address = 16'h0000;
        o_Mem_Data    = 8'h00;
        o_Mem_Write   = 1'b0;
        o_Mem_Read    = 1'b0;
        if (i_nRst) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_hits_ext) begin
                        o_Mem_Address = i_CPU_Address;
                        o_Mem_Data    = i_CPU_Data;
                        o_Mem_Write   = i_CPU_Write && i_Enable;
                        o_Mem_Read    = i_CPU_Read && !i_CPU_Write && i_Enable;
                    end
                end
                ST_START: begin
                    o_Mem_Address = {dma_reg_q, 8'h00};
                end
                ST_READ: begin
                    o_Mem_Address = {dma_reg_q, index_q};
                    o_Mem_Read    = i_Enable;
                end
                ST_WRITE: begin
                    o_Mem_Address = OAM_BASE + {8'h00, index_q};
                    o_Mem_Data    = byte_q;
                    o_Mem_Write   = i_Enable;
                end
                default: begin
                end
            endcase
        end
    end

    // Blocked external reads see 8'hFF; a simultaneous write wins over a read.
    always_comb begin
        o_CPU_Data = 8'h00;
        if (i_CPU_Read && !i_CPU_Write) begin
            if (cpu_hits_reg) begin
                o_CPU_Data = dma_reg_q;
            end else if (cpu_hits_hram) begin
                o_CPU_Data = hram_mem[hram_index];
            end else if (state_q == ST_IDLE) begin
                o_CPU_Data = i_Mem_Data;
            end else begin
                o_CPU_Data = 8'hFF;
            end
        end
    end

    assign o_DMA_Active = active_q;

`ifdef DMA_CPU_STALL_EN
    assign o_CPU_Wait = active_q;
`else
    assign o_CPU_Wait = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: memory model, queued expected strobes, per-cycle active/wait checks.
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic        dma_active;

    always #5 clk = ~clk;

    dma_bus_arbiter dut (
        .i_Clk         (clk),
        .i_nRst        (nrst),
        .i_Enable      (en),
        .i_CPU_Address (cpu_addr),
        .i_CPU_Data    (cpu_wdata),
        .i_CPU_Write   (cpu_wr),
        .i_CPU_Read    (cpu_rd),
        .o_CPU_Data    (cpu_rdata),
        .o_CPU_Wait    (cpu_wait),
        .i_Mem_Data    (mem_rdata),
        .o_Mem_Address (mem_addr),
        .o_Mem_Data    (mem_wdata),
        .o_Mem_Write   (mem_wr),
        .o_Mem_Read    (mem_rd),
        .o_DMA_Active  (dma_active)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } xact_t;

    xact_t exp_rd_q[$];
    xact_t exp_wr_q[$];

    int   checks   = 0;
    int   errors   = 0;
    int   en_count = 0;
    int   act_lo   = 1;
    int   act_hi   = 0;
    int   rd_seen  = 0;
    int   wr_seen  = 0;
    int   last_n   = 0;
    bit   chk_en   = 1'b0;
    bit   preload_req = 1'b0;

    logic [7:0] ext_mem [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC0;
    endfunction

    assign mem_rdata = ext_mem[mem_addr];

    always @(posedge clk) begin
        if (en) en_count <= en_count + 1;
        if (preload_req) begin
            for (int a = 0; a < 65536; a++) ext_mem[a] <= pat(16'(a));
        end else if (mem_wr) begin
            ext_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs every negedge: active/wait window and every memory strobe against the queues.
    task automatic monitor();
        xact_t e;
        logic  exp_act;
        logic  exp_wait;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_act = (en_count >= act_lo) && (en_count <= act_hi);
`ifdef DMA_CPU_STALL_EN
                exp_wait = exp_act;
`else
                exp_wait = 1'b0;
`endif
                checks++;
                assert (dma_active === exp_act) else begin
                    errors++;
                    $error("FAIL dma_active cyc=%0d observed=%b expected=%b", en_count, dma_active, exp_act);
                end
                checks++;
                assert (cpu_wait === exp_wait) else begin
                    errors++;
                    $error("FAIL cpu_wait cyc=%0d observed=%b expected=%b", en_count, cpu_wait, exp_wait);
                end
                if (nrst && mem_rd) begin
                    rd_seen++;
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        assert (exp_rd_q.size() != 0) else begin
                            errors++;
                            $error("FAIL rd_extra cyc=%0d observed addr=%h expected no strobe", en_count, mem_addr);
                        end
                    end else begin
                        e = exp_rd_q.pop_front();
                        assert (mem_addr === e.addr && en_count == e.cyc) else begin
                            errors++;
                            $error("FAIL rd_strobe observed addr=%h cyc=%0d expected addr=%h cyc=%0d",
                                   mem_addr, en_count, e.addr, e.cyc);
                        end
                    end
                end
                if (nrst && mem_wr) begin
                    wr_seen++;
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        assert (exp_wr_q.size() != 0) else begin
                            errors++;
                            $error("FAIL wr_extra cyc=%0d observed addr=%h data=%h expected no strobe",
                                   en_count, mem_addr, mem_wdata);
                        end
                    end else begin
                        e = exp_wr_q.pop_front();
                        assert (mem_addr === e.addr && mem_wdata === e.data && en_count == e.cyc) else begin
                            errors++;
                            $error("FAIL wr_strobe observed addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                                   mem_addr, mem_wdata, en_count, e.addr, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
    endtask

    task automatic do_preload();
        tick();
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    // Drives the register write in the current cycle and queues the expected strobes.
    task automatic dma_start(input logic [7:0] src, input bit restart);
        int    n;
        xact_t x;
        cpu_addr  = 16'hFF46;
        cpu_wdata = src;
        cpu_wr    = 1'b1;
        cpu_rd    = 1'b0;
        n = en_count;
        if (restart) begin
            while (exp_rd_q.size() > 0 && exp_rd_q[$].cyc > n) void'(exp_rd_q.pop_back());
            while (exp_wr_q.size() > 0 && exp_wr_q[$].cyc > n) void'(exp_wr_q.pop_back());
        end else begin
            act_lo = n + 1;
        end
        act_hi = n + 321;
        for (int k = 0; k < 160; k++) begin
            x.addr = {src, 8'(k)};
            x.data = 8'h00;
            x.cyc  = n + 2 + 2 * k;
            exp_rd_q.push_back(x);
            x.addr = 16'(16'hFE00 + k);
            x.data = pat({src, 8'(k)});
            x.cyc  = n + 3 + 2 * k;
            exp_wr_q.push_back(x);
        end
        last_n = n;
        $display("xact dma_start src=%h cyc=%0d restart=%0d", src, n, restart);
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (en_count < target && guard < 2000) begin
            tick();
            guard++;
        end
        chk("wait_until", 32'(en_count), 32'(target));
    endtask

    task automatic drain(input int budget);
        int guard = 0;
        while ((exp_rd_q.size() + exp_wr_q.size()) > 0 && guard < budget) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        chk("drain_empty", 32'(exp_rd_q.size() + exp_wr_q.size()), 32'd0);
    endtask

    task automatic check_oam(input string prefix, input logic [7:0] src, input int lo, input int hi);
        logic [15:0] a;
        for (int k = lo; k <= hi; k++) begin
            a = 16'(16'hFE00 + k);
            chk($sformatf("%s_k%0d", prefix, k), 32'(ext_mem[a]), 32'(pat({src, 8'(k)})));
        end
    endtask

    task automatic check_oam_orig(input string prefix, input int lo, input int hi);
        logic [15:0] a;
        for (int k = lo; k <= hi; k++) begin
            a = 16'(16'hFE00 + k);
            chk($sformatf("%s_k%0d", prefix, k), 32'(ext_mem[a]), 32'(pat(a)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_base;
        int wr_base;
        int n1;
        int r;

        fork
            monitor();
        join_none

        nrst = 1'b0;
        en   = 1'b1;
        cpu_idle();
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h77;
        cpu_rd    = 1'b1;
        do_preload();
        tick();
        @(negedge clk);
        chk("rst_active",   32'(dma_active), 32'd0);
        chk("rst_wait",     32'(cpu_wait),   32'd0);
        chk("rst_mem_rd",   32'(mem_rd),     32'd0);
        chk("rst_mem_wr",   32'(mem_wr),     32'd0);
        chk("rst_mem_addr", 32'(mem_addr),   32'd0);
        chk("rst_mem_data", 32'(mem_wdata),  32'd0);

        tick();
        nrst     = 1'b1;
        cpu_addr = 16'hFF46;
        cpu_rd   = 1'b1;
        chk_en   = 1'b1;
        @(negedge clk);
        chk("rst_dma_reg", 32'(cpu_rdata), 32'h00);

        // Transfer from C0 with CPU traffic while the port is owned by DMA
        rd_base = rd_seen;
        wr_base = wr_seen;
        tick();
        dma_start(8'hC0, 1'b0);
        tick();
        cpu_idle();
        cpu_addr = 16'hC123;
        cpu_rd   = 1'b1;
        @(negedge clk);
        chk("blk_rd", 32'(cpu_rdata), 32'hFF);
        tick();
        cpu_rd    = 1'b0;
        cpu_addr  = 16'hD000;
        cpu_wdata = 8'h11;
        cpu_wr    = 1'b1;
        @(negedge clk);
        chk("rd_low_zero", 32'(cpu_rdata), 32'h00);
        tick();
        cpu_addr  = 16'hFF90;
        cpu_wdata = 8'hAB;
        cpu_rd    = 1'b1;
        @(negedge clk);
        chk("rw_prio", 32'(cpu_rdata), 32'h00);
        tick();
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("hram_rd", 32'(cpu_rdata), 32'hAB);
        tick();
        cpu_addr = 16'hFF46;
        @(negedge clk);
        chk("reg_rd_active", 32'(cpu_rdata), 32'hC0);
        tick();
        cpu_idle();
        drain(400);
        chk("t1_rd_count", 32'(rd_seen - rd_base), 32'd160);
        chk("t1_wr_count", 32'(wr_seen - wr_base), 32'd160);
        chk("d000_kept", 32'(ext_mem[16'hD000]), 32'(pat(16'hD000)));
        check_oam("t1_oam", 8'hC0, 0, 159);
        $display("xact transfer1 done checks=%0d", checks);

        // Restart with D0 on the write of byte 40
        rd_base = rd_seen;
        wr_base = wr_seen;
        tick();
        dma_start(8'hC0, 1'b0);
        n1 = last_n;
        tick();
        cpu_idle();
        wait_until(n1 + 83);
        dma_start(8'hD0, 1'b1);
        tick();
        cpu_idle();
        drain(400);
        chk("t2_rd_count", 32'(rd_seen - rd_base), 32'd201);
        chk("t2_wr_count", 32'(wr_seen - wr_base), 32'd201);
        check_oam("t2_oam", 8'hD0, 0, 159);
        $display("xact restart done checks=%0d", checks);

        // Enable toggling every other cycle
        do_preload();
        rd_base = rd_seen;
        wr_base = wr_seen;
        tick();
        dma_start(8'hC0, 1'b0);
        for (int i = 0; i < 700; i++) begin
            tick();
            cpu_idle();
            en = i[0];
        end
        en = 1'b1;
        drain(400);
        chk("t3_rd_count", 32'(rd_seen - rd_base), 32'd160);
        chk("t3_wr_count", 32'(wr_seen - wr_base), 32'd160);
        check_oam("t3_oam", 8'hC0, 0, 159);
        $display("xact enable_toggle done checks=%0d", checks);

        // Reset in the read cycle of byte 80
        do_preload();
        rd_base = rd_seen;
        wr_base = wr_seen;
        tick();
        dma_start(8'hC0, 1'b0);
        n1 = last_n;
        tick();
        cpu_idle();
        wait_until(n1 + 162);
        r = en_count;
        while (exp_rd_q.size() > 0 && exp_rd_q[$].cyc >= r) void'(exp_rd_q.pop_back());
        while (exp_wr_q.size() > 0 && exp_wr_q[$].cyc >= r) void'(exp_wr_q.pop_back());
        act_hi = r;
        nrst   = 1'b0;
        @(negedge clk);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid_rd",   32'(mem_rd),   32'd0);
        tick();
        nrst     = 1'b1;
        cpu_addr = 16'hFF46;
        cpu_rd   = 1'b1;
        @(negedge clk);
        chk("rst_mid_reg",    32'(cpu_rdata),  32'h00);
        chk("rst_mid_active", 32'(dma_active), 32'd0);
        tick();
        cpu_idle();
        drain(50);
        chk("t4_rd_count", 32'(rd_seen - rd_base), 32'd80);
        chk("t4_wr_count", 32'(wr_seen - wr_base), 32'd80);
        check_oam("t4_oam_done", 8'hC0, 0, 79);
        check_oam_orig("t4_oam_kept", 80, 159);
        $display("xact reset_mid done checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the single external memory port and shares it between the CPU and an OAM DMA engine.
- A CPU write to the DMA register copies DMA_LENGTH bytes from page {src,8'h00} to OAM_BASE.
- During a transfer, CPU accesses outside HRAM are blocked. HRAM lives inside this block so the CPU can keep running from it while the DMA engine owns the port.

Parameters:
- DMA_REG_ADDR, 16'hFF46, address of the DMA source/start register
- DMA_LENGTH, 160, bytes per transfer (valid range 1..256)
- OAM_BASE, 16'hFE00, destination base address
- HRAM_LO, 16'hFF80, first HRAM address
- HRAM_HI, 16'hFFFE, last HRAM address (HRAM is 127x8, internal)

Ports:
- i_Clk  in  1  system clock
- i_nRst  in  1  synchronous reset, active low
- i_Enable  in  1  clock enable; all state advances only when high
- i_CPU_Address  in  16  CPU address
- i_CPU_Data  in  8  CPU write data
- i_CPU_Write  in  1  CPU write strobe
- i_CPU_Read  in  1  CPU read strobe
- o_CPU_Data  out  8  read data returned to CPU
- o_CPU_Wait  out  1  CPU stall request (see Optional Feature)
- i_Mem_Data  in  8  external memory read data, combinational in the same cycle
- o_Mem_Address  out  16  external memory address
- o_Mem_Data  out  8  external memory write data
- o_Mem_Write  out  1  external write strobe
- o_Mem_Read  out  1  external read strobe
- o_DMA_Active  out  1  high while a transfer is in progress

Behaviour:
- Clocking and reset:
  - Single clock i_Clk.
  - Reset is synchronous and active-low on i_nRst, and takes effect regardless of i_Enable.
- Reset values:
  - State is IDLE; DMA register = 8'h00; index = 0; byte latch = 0.
  - o_DMA_Active = 0 and o_CPU_Wait = 0.
  - o_Mem_Write = 0 and o_Mem_Read = 0; o_Mem_Address and o_Mem_Data are forced to 0 while i_nRst is low.
  - HRAM contents are not cleared.
  - Reset mid-transfer aborts immediately; no further memory strobes are issued.
- FSM states: IDLE, START, READ, WRITE. Transitions happen only on edges where i_Enable = 1.
  - IDLE -> START on a CPU write to DMA_REG_ADDR; the register latches i_CPU_Data.
  - START -> READ; index cleared to 0.
  - READ: drives {src,index[7:0]}, asserts o_Mem_Read, latches i_Mem_Data. Then -> WRITE.
  - WRITE: drives OAM_BASE+index and the latched byte, asserts o_Mem_Write.
    - If index == DMA_LENGTH-1: -> IDLE.
    - Otherwise: index+1 and -> READ.
- Timing:
  - A register write accepted at enabled cycle N gives byte k read at N+2+2k and written at N+3+2k.
  - The final write (k=159) occurs at N+321.
  - o_DMA_Active is registered: high in cycles N+1..N+321 inclusive.
- Source page:
  - Used unchanged, with no echo remapping; source 8'hFE reads OAM itself.
  - Index is 8 bits; address low byte = index, so there is no carry into the high byte.
- CPU path, combinational, evaluated every cycle:
  - DMA_REG_ADDR: reads return the register; writes are intercepted, never forwarded, and accepted even while active.
  - HRAM_LO..HRAM_HI: internal HRAM.
    - Combinational read.
    - Write on an enabled edge.
    - Never touches the memory port, so it is always allowed.
  - Other addresses, IDLE: forwarded to the memory port; o_CPU_Data = i_Mem_Data during reads.
  - Other addresses, START/READ/WRITE: blocked.
    - Reads return 8'hFF.
    - Writes are dropped.
    - No CPU strobe reaches memory.
  - o_CPU_Data = 8'h00 when i_CPU_Read is low.
- Simultaneous events:
  - A CPU write to DMA_REG_ADDR while active restarts: the current-cycle DMA strobe completes, the register reloads, and the FSM goes to START (index re-cleared on the START->READ edge).
  - A write to DMA_REG_ADDR in the same edge as the final WRITE restarts rather than going IDLE.
  - i_CPU_Read and i_CPU_Write both high: the write takes priority and o_CPU_Data = 8'h00.
- i_Enable low: the FSM, index, and registers hold. Outputs keep driving the current state's address/data, but strobes are gated low.

Optional Feature:
- Macro: DMA_CPU_STALL_EN.
- Defined:
  - o_CPU_Wait = o_DMA_Active.
  - The CPU is expected to hold while waiting; blocked accesses still return 8'hFF.
- Undefined: o_CPU_Wait is tied 0 and the CPU runs freely under the blocking rules above.

Test Plan:
- Reset, then write 8'hC0 to FF46 at cycle N, with memory preloaded so C000+k = k^8'h5A -> FE00..FE9F hold k^8'h5A; o_DMA_Active is high N+1..N+321; exactly 160 read and 160 write strobes.
- During DMA, CPU reads C123 and writes D000=8'h11 -> CPU reads 8'hFF; D000 unchanged; no CPU strobe on the port. Then CPU writes FF90=8'hAB and reads it back -> 8'hAB.
- Restart: write 8'hC0, then write 8'hD0 at byte k=40 -> FE00..FE9F end with the D0xx pattern; o_DMA_Active stays high continuously until 321 enabled cycles after the second write.
- Toggle i_Enable low every other cycle during a transfer -> identical OAM contents; the last write lands at the 321st enabled cycle.
- Assert i_nRst low at byte 80 -> no strobes from the next cycle; FF46 reads 8'h00; o_DMA_Active = 0; FE50..FE9F unchanged.
- With DMA_CPU_STALL_EN defined, o_CPU_Wait equals o_DMA_Active in every cycle; without it, o_CPU_Wait stays 0 throughout.
